uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: the receive-side counterpart of `uart_tx` in the same serial link. It recovers 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity) from the asynchronous `uart_rxd` pin. Each bit is sampled at mid-bit using a system-clock baud counter. Every accepted byte is presented with a one-cycle strobe, and a bad stop bit is flagged. The block sits between the board RX pin and the byte-level consumer logic.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `UART_BPS`, default 115200: baud rate.
- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `uart_rxd`, input, 1: serial RX pin, asynchronous to `clk`; idle level is high.
- `uart_rx_data`, output, 8: last correctly received byte; holds its value until the next good frame.
- `uart_rx_done`, output, 1: one-cycle pulse; `uart_rx_data` is valid in that cycle.
- `uart_rx_frame_err`, output, 1: one-cycle pulse; the stop bit was sampled low.
- `uart_rx_busy`, output, 1: high while a frame is being received (state != ST_IDLE).

## Operation
- Constants:
  - BAUD_CNT_MAX = CLK_FREQ / UART_BPS, integer division (434 at the defaults).
  - HALF_BIT = BAUD_CNT_MAX / 2 (217).
  - Elaboration check: 4 ≤ BAUD_CNT_MAX ≤ 65535.
- Synchronizer: `uart_rxd` passes through 2 flops, both reset to 1, to give `rxd_s`.
  - A third flop holds `rxd_d`.
  - Falling edge = `rxd_d` & !`rxd_s`.
- `baud_cnt`: 16 bits.
  - Cleared in ST_IDLE and on every state change.
  - Otherwise increments, wrapping to 0 at the state's terminal count.
- FSM states:
  - ST_IDLE → ST_START on a falling edge.
  - ST_START: at `baud_cnt` == HALF_BIT-1, sample `rxd_s`.
    - 0 → ST_DATA, with `bit_idx` = 0.
    - 1 (glitch) → ST_IDLE, no flags raised.
  - ST_DATA: at `baud_cnt` == BAUD_CNT_MAX-1, shift `rxd_s` into bit 7 of the shift register (shift right) and increment `bit_idx`.
    - After the sample with `bit_idx` == 7 → ST_STOP.
  - ST_STOP: at `baud_cnt` == BAUD_CNT_MAX-1, sample `rxd_s`.
    - 1 → `uart_rx_data` <= shift register, `uart_rx_done` <= 1.
    - 0 → `uart_rx_frame_err` <= 1; `uart_rx_data` unchanged.
    - Either way → ST_IDLE at mid-stop-bit, so the receiver can resync on the next start edge.
- After a frame error the line may still be low. A new frame starts only on a fresh high→low edge; a held-low line (break) produces no further frames.
- There is no overrun protection. The consumer must take the byte on `uart_rx_done`; the next frame overwrites it.

## Timing
- Reset values:
  - Outputs: `uart_rx_data` = 8'h00, `uart_rx_done` = 0, `uart_rx_frame_err` = 0, `uart_rx_busy` = 0.
  - Internal: FSM = ST_IDLE, `baud_cnt` = 0, `bit_idx` = 0, shift register = 0, synchronizer flops = 1.
- Asserting `rst_n` mid-frame aborts the frame with no pulses. After release the receiver waits for the next falling edge.
- Latency, pin falling edge to ST_START: 3 clk (2 for the synchronizer, 1 for edge detect).
- Latency, pin falling edge to the `uart_rx_done` / `uart_rx_frame_err` pulse: 3 + HALF_BIT + 9·BAUD_CNT_MAX clk = 4126 at the defaults.
- Data-bit sample points: HALF_BIT + k·BAUD_CNT_MAX clk after start detect, for k = 1..8.
- Both pulses are registered, exactly 1 cycle wide, and never asserted together.
- `uart_rx_busy` is combinational from the state register. It falls in the same cycle the done or error pulse rises.
- Back-to-back frames with zero idle bits are supported: the next start edge arrives about HALF_BIT cycles after the receiver returns to ST_IDLE.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum {ST_IDLE, ST_START, ST_DATA, ST_STOP}.
  - Frame constants DATA_BITS = 8 and STOP_BITS = 1.
  - Function `baud_div(clk_freq, bps)`, also used by `uart_tx`.
- One sub-module: `uart_sync`, a parameterizable N-flop synchronizer with a reset value parameter. Used here with N = 2 and reset value 1.

## Test plan
- Defaults; send 0xA5 at the exact baud rate → a single `uart_rx_done` pulse 4126 ±1 clk after the falling edge; `uart_rx_data` = 8'hA5; `uart_rx_frame_err` never asserts.
- 100-clk low glitch on an idle line → no `uart_rx_done` or `uart_rx_frame_err`; `uart_rx_busy` is high for ~217 clk, then returns to 0.
- Send 0x3C with the stop bit driven 0 → one `uart_rx_frame_err` pulse; `uart_rx_data` keeps its previous value 8'hA5; no `uart_rx_done`.
- Back-to-back 0x00 then 0xFF with zero idle gap, then 0x55 with the bit period stretched +3% → three done pulses with data 00, FF, 55 in order.
- Assert `rst_n` low during data bit 4 of 0x81, release, then send 0x7E → all outputs are at reset values during reset; no pulse for the aborted frame; then a done pulse with data 0x7E.
- Hold the line low for 20 bit periods, then release high → exactly one `uart_rx_frame_err` pulse and no further pulses until a new start edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx and uart_tx.
// Holds the frame format constants, the receiver state encoding and the
// baud divisor helper, so both directions of the link agree on timing.
package uart_pkg;

  // 8N1 frame format.
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Receiver FSM states. The encoding is fixed so that external tools and
  // older logic that probe the state register keep working.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // System clocks per bit, rounded down (integer division).
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for a single asynchronous input bit.
//
// Parameters:
//   N       - number of flops in the chain (at least 2)
//   RST_VAL - value every flop takes during reset
// Ports:
//   clk   - destination clock domain, rising edge
//   rst_n - asynchronous active-low reset
//   d_i   - asynchronous input
//   q_o   - synchronized output (last flop of the chain)
module uart_sync #(
  parameter int unsigned N       = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  if (N < 2) begin : gen_bad_depth
    $error("uart_sync: N must be at least 2");
  end

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {N{RST_VAL}};
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver for 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity).
// Each bit is sampled once at its middle using a system-clock baud counter.
// A good frame updates uart_rx_data and pulses uart_rx_done; a low stop bit
// pulses uart_rx_frame_err and leaves uart_rx_data untouched.
//
// Parameters:
//   CLK_FREQ - system clock frequency in Hz
//   UART_BPS - baud rate
// Ports:
//   clk               - system clock, rising edge
//   rst_n             - asynchronous active-low reset
//   uart_rxd          - serial RX pin, asynchronous, idles high
//   uart_rx_data      - last correctly received byte, held until the next good frame
//   uart_rx_done      - one-cycle pulse, uart_rx_data valid in that cycle
//   uart_rx_frame_err - one-cycle pulse, stop bit was sampled low
//   uart_rx_busy      - high while a frame is in progress
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] uart_rx_data,
  output logic                 uart_rx_done,
  output logic                 uart_rx_frame_err,
  output logic                 uart_rx_busy
);

  localparam int unsigned BAUD_CNT_MAX = baud_div(CLK_FREQ, UART_BPS);
  localparam int unsigned HALF_BIT     = BAUD_CNT_MAX / 2;

  if (BAUD_CNT_MAX < 4 || BAUD_CNT_MAX > 65535) begin : gen_bad_baud
    $error("uart_rx: CLK_FREQ / UART_BPS must lie in 4..65535");
  end

  // Terminal counts: half a bit from the start edge to mid-start, then one
  // full bit between consecutive mid-bit sample points.
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);

  localparam int unsigned          IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer and falling-edge detect
  // ---------------------------------------------------------------------------
  logic rxd_s;
  logic rxd_dly_q;
  logic rxd_fall;

  uart_sync #(
    .N       (2),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (uart_rxd),
    .q_o   (rxd_s)
  );

  // Reset high so that a line already low at reset release is not taken as
  // a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_dly_q <= 1'b1;
    end else begin
      rxd_dly_q <= rxd_s;
    end
  end

  assign rxd_fall = rxd_dly_q & ~rxd_s;

  // ---------------------------------------------------------------------------
  // Receive FSM, baud counter and data path
  // ---------------------------------------------------------------------------
  rx_state_t              state_q,    state_d;
  logic [15:0]            baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0]       bit_idx_q,  bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q,    shift_d;
  logic [DATA_BITS-1:0]   data_q,     data_d;
  logic                   done_q,     done_d;
  logic                   err_q,      err_d;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (rxd_fall) begin
          state_d = ST_START;
        end
      end

      // Re-check the line at mid-start; a high level means the edge was a
      // glitch and we drop back silently.
      ST_START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          if (!rxd_s) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      // LSB arrives first, so shift right and insert at the MSB.
      ST_DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d  = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      // Leave at mid-stop-bit so a back-to-back start edge is not missed.
      ST_STOP: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          state_d    = ST_IDLE;
          if (rxd_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_done      = done_q;
  assign uart_rx_frame_err = err_q;
  assign uart_rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at the default 50 MHz / 115200 baud.
module tb_uart_rx;

  localparam int unsigned ClkFreq = 50_000_000;
  localparam int unsigned Bps     = 115200;
  localparam int          BitClk  = ClkFreq / Bps;           // 434
  localparam int          HalfClk = BitClk / 2;              // 217
  localparam int          DoneLat = 3 + HalfClk + 9 * BitClk; // 4126

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd   = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;
  logic       rx_busy;

  always #10 clk = ~clk;

  uart_rx #(
    .CLK_FREQ (ClkFreq),
    .UART_BPS (Bps)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .uart_rxd          (rxd),
    .uart_rx_data      (rx_data),
    .uart_rx_done      (rx_done),
    .uart_rx_frame_err (rx_err),
    .uart_rx_busy      (rx_busy)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;
  int unsigned fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor: collects every pulse as an event
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int unsigned cyc;
  } ev_t;

  ev_t  got_q[$];
  logic done_prev = 1'b0;
  logic err_prev  = 1'b0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_done || rx_err) begin
      check("pulse_exclusive", 32'(rx_done & rx_err), 32'd0);
      check("pulse_width", 32'((rx_done & done_prev) | (rx_err & err_prev)), 32'd0);
      check("busy_falls_with_pulse", 32'({busy_prev, rx_busy}), 32'b10);
      got_q.push_back('{is_err: bit'(rx_err), data: rx_data, cyc: cyc});
    end
    done_prev = rx_done;
    err_prev  = rx_err;
    busy_prev = rx_busy;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (always entered and left on a falling clock edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk);
    fall_cyc = cyc;
    drive(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive(b[i], bclk);
    drive(stop, bclk);
  endtask

  // Reference model: a frame is just a byte plus a stop level. A good stop
  // yields a done event carrying the byte; a bad one yields an error event
  // while the output register keeps the last good byte.
  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      last_good = b;
      exp_q.push_back('{is_err: 1'b0, data: b, cyc: 0});
    end else begin
      exp_q.push_back('{is_err: 1'b1, data: last_good, cyc: 0});
    end
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_event_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      ev_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_is_err"}, 32'(g.is_err), 32'(e.is_err));
      check({tag, "_data"}, 32'(g.data), 32'(e.data));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: stimulus plus hand-derived expected outcome
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bclk;
    int         idle;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int glitch_busy;
    int lat;

    // 3C with a bad stop, then 00/FF back-to-back, then 55 with bits 3% long.
    vecs[0] = '{data: 8'h3C, stop: 1'b0, bclk: BitClk, idle: BitClk, exp_err: 1'b1,
                exp_data: 8'hA5};
    vecs[1] = '{data: 8'h00, stop: 1'b1, bclk: BitClk, idle: 0, exp_err: 1'b0,
                exp_data: 8'h00};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, bclk: BitClk, idle: 0, exp_err: 1'b0,
                exp_data: 8'hFF};
    vecs[3] = '{data: 8'h55, stop: 1'b1, bclk: 447, idle: BitClk, exp_err: 1'b0,
                exp_data: 8'h55};

    // Reset values.
    repeat (5) @(negedge clk);
    check("reset_data", 32'(rx_data), 32'h00);
    check("reset_done", 32'(rx_done), 32'd0);
    check("reset_err", 32'(rx_err), 32'd0);
    check("reset_busy", 32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 0xA5 at the exact baud rate, with latency check.
    send_frame(8'hA5, 1'b1, BitClk);
    drive(1'b1, BitClk);
    check("a5_event_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      check("a5_is_err", 32'(got_q[0].is_err), 32'd0);
      check("a5_data", 32'(got_q[0].data), 32'hA5);
      lat = int'(got_q[0].cyc - fall_cyc);
      n_cmp++;
      if (lat < DoneLat - 1 || lat > DoneLat + 1) begin
        n_bad++;
        $display("FAIL a5_latency: got %0d, expected %0d +/-1", lat, DoneLat);
      end
    end
    got_q.delete();
    last_good = 8'hA5;

    // 100-clk glitch: busy for about half a bit, no pulses.
    glitch_busy = 0;
    rxd = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 100) rxd = 1'b1;
      @(negedge clk);
      if (rx_busy) glitch_busy++;
    end
    n_cmp++;
    if (glitch_busy < HalfClk - 1 || glitch_busy > HalfClk + 1) begin
      n_bad++;
      $display("FAIL glitch_busy_len: got %0d, expected %0d +/-1", glitch_busy, HalfClk);
    end
    check("glitch_no_pulse", 32'(got_q.size()), 32'd0);
    check("glitch_busy_end", 32'(rx_busy), 32'd0);
    got_q.delete();

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].bclk);
      drive(1'b1, vecs[v].idle);
      check($sformatf("vec%0d_event_count", v), 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d_is_err", v), 32'(got_q[0].is_err), 32'(vecs[v].exp_err));
        check($sformatf("vec%0d_pulse_data", v), 32'(got_q[0].data), 32'(vecs[v].exp_data));
      end
      check($sformatf("vec%0d_data_hold", v), 32'(rx_data), 32'(vecs[v].exp_data));
      got_q.delete();
    end
    last_good = 8'h55;

    // Reset during data bit 4 of 0x81, then 0x7E.
    drive(1'b0, BitClk);
    for (int i = 0; i < 4; i++) drive(logic'(8'h81 >> i), BitClk);
    drive(1'b0, 200);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_data", 32'(rx_data), 32'h00);
    check("midreset_done", 32'(rx_done), 32'd0);
    check("midreset_err", 32'(rx_err), 32'd0);
    check("midreset_busy", 32'(rx_busy), 32'd0);
    drive(1'b1, 20);
    rst_n = 1'b1;
    drive(1'b1, 2 * BitClk);
    check("aborted_no_pulse", 32'(got_q.size()), 32'd0);
    check("after_reset_busy", 32'(rx_busy), 32'd0);
    got_q.delete();
    last_good = 8'h00;
    send_frame(8'h7E, 1'b1, BitClk);
    drive(1'b1, BitClk);
    model_frame(8'h7E, 1'b1);
    compare_events("post_reset");

    // Break: line low for 20 bits -> exactly one frame error.
    drive(1'b0, 20 * BitClk);
    drive(1'b1, 2 * BitClk);
    model_frame(8'h00, 1'b0);
    compare_events("break");
    check("break_data_hold", 32'(rx_data), 32'h7E);
    check("break_busy_end", 32'(rx_busy), 32'd0);

    // Randomised frames against the model.
    for (int f = 0; f < 4; f++) begin
      logic [7:0] b;
      logic       stop;
      int         bclk;
      int         gap;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      bclk = BitClk + int'($urandom_range(0, 16)) - 8;
      // After a low stop the line needs a high gap, or no new edge exists.
      gap  = stop ? int'($urandom_range(0, 300)) : int'($urandom_range(50, 300));
      send_frame(b, stop, bclk);
      drive(1'b1, gap);
      model_frame(b, stop);
      compare_events($sformatf("rand%0d", f));
      check($sformatf("rand%0d_data_hold", f), 32'(rx_data), 32'(last_good));
    end
    drive(1'b1, BitClk);
    check("final_no_stray_pulse", 32'(got_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
